// File: rtl/stream_arbiter.sv
// Round-robin packet arbiter: locks one source per packet, beats pass combinationally (zero latency),
// backpressure goes straight through to the owner; packets longer than MAX_BEATS are cut with a trunc pulse.
module stream_arbiter #(
  parameter int PACK_SIZE = 8,
  parameter int N_SRC     = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*PACK_SIZE-1:0] src_data,
  input  logic [N_SRC-1:0]           src_last,
  output logic [N_SRC-1:0]           src_ready,
  input  logic                       ready,
  output logic                       valid,
  output logic [PACK_SIZE-1:0]       data_out,
  output logic                       last,
  output logic [N_SRC-1:0]           grant,
  output logic                       trunc
);

  localparam int PW = $clog2(N_SRC);
  localparam int CW = ($clog2(MAX_BEATS) < 4) ? 4 : $clog2(MAX_BEATS);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trunc_q, trunc_d;

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic          cnt_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= PW'(N_SRC - 1);
      cnt_q    <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
    end
  end

  // First requester strictly after the previous owner, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!pick_vld && src_valid[(int'(rr_ptr_q) + k) % N_SRC]) begin
        pick_vld = 1'b1;
        pick_idx = PW'((int'(rr_ptr_q) + k) % N_SRC);
      end
    end
  end

  assign cnt_max = (cnt_q == CW'(MAX_BEATS - 1));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    trunc_d   = 1'b0;
    valid     = 1'b0;
    data_out  = '0;
    last      = 1'b0;
    src_ready = '0;
    grant     = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOCK;
          owner_d = pick_idx;
        end
      end
      LOCK: begin
        grant[owner_q]     = 1'b1;
        valid              = src_valid[owner_q];
        data_out           = src_data[owner_q*PACK_SIZE +: PACK_SIZE];
        src_ready[owner_q] = ready;
        last               = src_last[owner_q] | cnt_max;
        if (valid && ready) begin
          if (last) begin
            state_d  = IDLE;
            rr_ptr_d = owner_q;
            cnt_d    = '0;
            trunc_d  = cnt_max & ~src_last[owner_q];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign trunc = trunc_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: directed vector table, hand-written corner sequences, and a
// randomized run compared cycle by cycle against a packet-level reference model.
module tb_stream_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   src_valid;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_ready;
  logic           ready;
  logic           valid;
  logic [W-1:0]   data_out;
  logic           last;
  logic [N-1:0]   grant;
  logic           trunc;

  int n_tests = 0;
  int n_fail  = 0;

  stream_arbiter #(.PACK_SIZE(W), .N_SRC(N), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .ready(ready), .valid(valid), .data_out(data_out), .last(last),
    .grant(grant), .trunc(trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] sv;
    logic [N-1:0] sl;
    logic         rdy;
    logic [N-1:0] g;
    logic         v;
    logic [W-1:0] d;
    logic         l;
    logic [N-1:0] sr;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] g, input logic v, input logic [W-1:0] d,
                         input logic l, input logic [N-1:0] sr, input logic t);
    chk({tag, " grant"},     32'(grant),     32'(g));
    chk({tag, " valid"},     32'(valid),     32'(v));
    chk({tag, " data_out"},  32'(data_out),  32'(d));
    chk({tag, " last"},      32'(last),      32'(l));
    chk({tag, " src_ready"}, 32'(src_ready), 32'(sr));
    chk({tag, " trunc"},     32'(trunc),     32'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    src_valid = '0;
    src_last  = '0;
    reset     = 1'b1;
    #2;
    reset     = 1'b0;
  endtask

  // Reference model state: packet owner (-1 = idle), beats already accepted, previous owner.
  int       m_owner, m_beats, m_prev;
  logic     m_trunc;
  logic [N-1:0] e_g, e_sr;
  logic     e_v, e_l;
  logic [W-1:0] e_d;
  bit       found;

  initial begin
    reset     = 1'b1;
    src_valid = '1;
    src_last  = '1;
    ready     = 1'b1;
    src_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #2;
    chk_all("reset", '0, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // All sources always valid with 1-beat packets: rotating grants separated by one idle cycle.
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b1, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 1'b1, 4'b0010};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};
    tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b1, 4'b0100};
    tbl[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};
    tbl[7]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 1'b1, 4'b1000};
    tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};
    tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b1, 4'b0001};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      src_valid = tbl[i].sv;
      src_last  = tbl[i].sl;
      ready     = tbl[i].rdy;
      #1;
      chk_all($sformatf("tbl%0d", i), tbl[i].g, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].sr, 1'b0);
      tick();
    end

    // Sources 1 and 3, 3-beat packets each, ready held high.
    pulse_reset();
    ready = 1'b1;
    src_valid = 4'b1010;
    #1;
    chk("rr idle0 grant", 32'(grant), 32'h0);
    tick();
    for (int b = 0; b < 3; b++) begin
      src_data[1*W +: W] = 8'h10 + 8'(b);
      src_last = (b == 2) ? 4'b0010 : 4'b0000;
      #1;
      chk($sformatf("rr s1 b%0d grant", b), 32'(grant), 32'b0010);
      chk($sformatf("rr s1 b%0d data", b), 32'(data_out), 32'(8'h10 + 8'(b)));
      chk($sformatf("rr s1 b%0d last", b), 32'(last), 32'(b == 2));
      tick();
    end
    src_last = '0;
    #1;
    chk("rr idle1 grant", 32'(grant), 32'h0);
    tick();
    for (int b = 0; b < 3; b++) begin
      src_data[3*W +: W] = 8'h30 + 8'(b);
      src_last = (b == 2) ? 4'b1000 : 4'b0000;
      #1;
      chk($sformatf("rr s3 b%0d grant", b), 32'(grant), 32'b1000);
      chk($sformatf("rr s3 b%0d data", b), 32'(data_out), 32'(8'h30 + 8'(b)));
      tick();
    end

    // Owner 1 finishes while sources 1 and 2 request: source 2 must win.
    pulse_reset();
    src_valid = 4'b0010;
    src_last  = 4'b0010;
    tick();
    src_valid = 4'b0110;
    #1;
    chk("skip lock grant", 32'(grant), 32'b0010);
    tick();
    #1;
    chk("skip idle grant", 32'(grant), 32'h0);
    tick();
    chk("skip next grant", 32'(grant), 32'b0100);

    // Source 2 streams 20 beats without last: cut at beat 16, remainder becomes a new packet.
    pulse_reset();
    src_valid = 4'b0100;
    src_last  = '0;
    tick();
    for (int b = 0; b < 16; b++) begin
      src_data[2*W +: W] = 8'(b);
      #1;
      chk($sformatf("trc b%0d grant", b), 32'(grant), 32'b0100);
      chk($sformatf("trc b%0d data", b), 32'(data_out), 32'(b));
      chk($sformatf("trc b%0d last", b), 32'(last), 32'(b == 15));
      chk($sformatf("trc b%0d trunc", b), 32'(trunc), 32'h0);
      tick();
    end
    #1;
    chk("trc pulse", 32'(trunc), 32'h1);
    chk("trc idle grant", 32'(grant), 32'h0);
    tick();
    for (int b = 16; b < 20; b++) begin
      src_data[2*W +: W] = 8'(b);
      src_last = (b == 19) ? 4'b0100 : 4'b0000;
      #1;
      chk($sformatf("trc b%0d grant", b), 32'(grant), 32'b0100);
      chk($sformatf("trc b%0d last", b), 32'(last), 32'(b == 19));
      chk($sformatf("trc b%0d trunc", b), 32'(trunc), 32'h0);
      tick();
    end
    #1;
    chk("trc end trunc", 32'(trunc), 32'h0);

    // Reset lands on beat 2 of a packet from source 1.
    pulse_reset();
    src_valid = 4'b0010;
    tick();
    tick();
    chk("rst beat2 valid", 32'(valid), 32'h1);
    reset = 1'b1;
    #1;
    chk_all("rst mid", '0, 1'b0, '0, 1'b0, '0, 1'b0);
    src_valid = 4'b1000;
    #1;
    reset = 1'b0;
    tick();
    chk("rst resume grant", 32'(grant), 32'b1000);

    // Randomized traffic against the packet-level model.
    pulse_reset();
    m_owner = -1;
    m_beats = 0;
    m_prev  = N - 1;
    m_trunc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      src_valid = 4'($urandom);
      for (int s = 0; s < N; s++) src_last[s] = ($urandom_range(0, 11) == 0);
      src_data  = $urandom;
      ready     = ($urandom_range(0, 3) != 0);
      #1;
      e_g = '0; e_v = 1'b0; e_d = '0; e_l = 1'b0; e_sr = '0;
      if (m_owner >= 0) begin
        e_g[m_owner]  = 1'b1;
        e_v           = src_valid[m_owner];
        e_d           = src_data[m_owner*W +: W];
        e_l           = src_last[m_owner] || (m_beats == MB - 1);
        e_sr[m_owner] = ready;
      end
      chk_all($sformatf("rnd%0d", c), e_g, e_v, e_d, e_l, e_sr, m_trunc);
      m_trunc = 1'b0;
      if (m_owner < 0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && src_valid[(m_prev + k) % N]) begin
            found   = 1;
            m_owner = (m_prev + k) % N;
          end
        end
      end else if (e_v && ready) begin
        if (e_l) begin
          m_trunc = (m_beats == MB - 1) && !src_last[m_owner];
          m_prev  = m_owner;
          m_owner = -1;
          m_beats = 0;
        end else begin
          m_beats++;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
